load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 27 ++
 rtl/load_store_unit_extender.sv | 38 +++
 rtl/load_store_unit.sv | 192 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit: funct3 size codes, error codes,
// FSM state encoding and the byte-lane count of a data word.
package load_store_unit_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_D  = 3'b011;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;
    localparam logic [2:0] SZ_WU = 3'b110;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_SIZE     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_FAIL = 2'd3;

    function automatic int lane_count(input int xlen);
        return xlen / 8;
    endfunction

endpackage

// File: rtl/load_store_unit_extender.sv
// Picks the addressed lane out of a memory word, moves it to bit 0 and
// sign- or zero-extends it according to the funct3 size code.
module load_extender
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]              i_data,
    input  logic [$clog2(XLEN/8)-1:0]    i_off,
    input  logic [2:0]                   i_size,
    output logic [XLEN-1:0]              o_data
);

    logic [XLEN-1:0] w_lane;
    logic            w_sign;
    int              w_width;

    assign w_lane = i_data >> {i_off, 3'b000};

    always_comb begin
        w_width = XLEN;
        w_sign  = 1'b0;
        case (i_size[1:0])
            2'b00:   begin w_width = 8;  w_sign = w_lane[7];  end
            2'b01:   begin w_width = 16; w_sign = w_lane[15]; end
            2'b10:   begin w_width = 32; w_sign = w_lane[31]; end
            default: begin w_width = XLEN; w_sign = w_lane[XLEN-1]; end
        endcase
        // Unsigned codes (BU/HU/WU) have bit 2 set.
        if (i_size[2]) begin
            w_sign = 1'b0;
        end
        for (int i = 0; i < XLEN; i++) begin
            o_data[i] = (i < w_width) ? w_lane[i] : w_sign;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: validates the request, drives one
// memory access with a stall timeout, and returns the extended load data.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                is_store,
    input  logic [2:0]          size,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [XLEN-1:0]     wdata,
    output logic                busy,
    output logic                done,
    output logic [XLEN-1:0]     rdata,
    output logic [1:0]          err_code,
    output logic                mem_req,
    output logic                mem_we,
    output logic [XLEN/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_ack,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int NB    = lane_count(XLEN);
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [NB-1:0]     r_mem_be;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [XLEN-1:0]   r_mem_wdata;
    logic              r_done;
    logic [XLEN-1:0]   r_rdata;
    logic [1:0]        r_err;
    logic [2:0]        r_size;
    logic [OFF_W-1:0]  r_off;
    logic              r_is_store;

    logic              w_legal;
    logic              w_misalign;
    logic [2:0]        w_align_mask;
    logic [NB-1:0]     w_lane_mask;
    logic [XLEN-1:0]   w_rep;
    logic [OFF_W-1:0]  w_off;
    logic [XLEN-1:0]   w_ext;

    assign w_off = addr[OFF_W-1:0];

    always_comb begin
        w_legal = 1'b0;
        case (size)
            SZ_B, SZ_H, SZ_W: w_legal = 1'b1;
            SZ_BU, SZ_HU:     w_legal = !is_store;
            SZ_D:             w_legal = (XLEN == 64);
            SZ_WU:            w_legal = (XLEN == 64) && !is_store;
            default:          w_legal = 1'b0;
        endcase
    end

    // Mask, lane enables and store replication all follow the access width.
    always_comb begin
        case (size[1:0])
            2'b00: begin
                w_align_mask = 3'b000;
                w_lane_mask  = NB'(1);
                w_rep        = {NB{wdata[7:0]}};
            end
            2'b01: begin
                w_align_mask = 3'b001;
                w_lane_mask  = NB'(3);
                w_rep        = {(NB/2){wdata[15:0]}};
            end
            2'b10: begin
                w_align_mask = 3'b011;
                w_lane_mask  = NB'(15);
                w_rep        = {(NB/4){wdata[31:0]}};
            end
            default: begin
                w_align_mask = 3'b111;
                w_lane_mask  = {NB{1'b1}};
                w_rep        = wdata;
            end
        endcase
        w_misalign = |(addr[2:0] & w_align_mask);
    end

    load_extender #(.XLEN(XLEN)) u_ext (
        .i_data (mem_rdata),
        .i_off  (r_off),
        .i_size (r_size),
        .o_data (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
            r_rdata     <= '0;
            r_err       <= ERR_OK;
            r_size      <= '0;
            r_off       <= '0;
            r_is_store  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A done pulse that lands in IDLE (error path) still blocks acceptance.
                    if (start && !r_done) begin
                        r_size     <= size;
                        r_off      <= w_off;
                        r_is_store <= is_store;
                        if (!w_legal) begin
                            r_err   <= ERR_SIZE;
                            r_state <= ST_FAIL;
                        end else if (w_misalign) begin
                            r_err   <= ERR_MISALIGN;
                            r_state <= ST_FAIL;
                        end else begin
                            r_err       <= ERR_OK;
                            r_state     <= ST_REQ;
                            r_cnt       <= CNT_W'(1);
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= is_store;
                            r_mem_be    <= w_lane_mask << w_off;
                            r_mem_addr  <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            r_mem_wdata <= w_rep;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        r_state     <= ST_RESP;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_be    <= '0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        r_done      <= 1'b1;
                        r_rdata     <= r_is_store ? '0 : w_ext;
                    end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                        r_state     <= ST_FAIL;
                        r_err       <= ERR_TIMEOUT;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_be    <= '0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                ST_FAIL: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                    r_rdata <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign rdata     = r_rdata;
    assign err_code  = r_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a 32-bit instance (TIMEOUT=4) and a
// 64-bit instance share stimulus; results are scored against an expected queue.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        sel64;

    logic        busy32, done32, req32, we32;
    logic [31:0] rdata32, maddr32, mwd32;
    logic [1:0]  err32;
    logic [3:0]  be32;
    logic        busy64, done64, req64, we64;
    logic [63:0] rdata64, mwd64;
    logic [31:0] maddr64;
    logic [1:0]  err64;
    logic [7:0]  be64;

    logic        v_busy, v_done, v_req, v_we;
    logic [63:0] v_rdata, v_wdata;
    logic [31:0] v_addr;
    logic [1:0]  v_err;
    logic [7:0]  v_be;

    logic [65:0] exp_q[$];
    int          n_cmp;
    int          n_fail;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) u_dut32 (
        .clk(clk), .rst(rst), .start(start & ~sel64), .is_store(is_store),
        .size(size), .addr(addr), .wdata(wdata[31:0]),
        .busy(busy32), .done(done32), .rdata(rdata32), .err_code(err32),
        .mem_req(req32), .mem_we(we32), .mem_be(be32), .mem_addr(maddr32),
        .mem_wdata(mwd32), .mem_ack(mem_ack & ~sel64), .mem_rdata(mem_rdata[31:0])
    );

    load_store_unit #(.XLEN(64), .ADDR_W(32)) u_dut64 (
        .clk(clk), .rst(rst), .start(start & sel64), .is_store(is_store),
        .size(size), .addr(addr), .wdata(wdata),
        .busy(busy64), .done(done64), .rdata(rdata64), .err_code(err64),
        .mem_req(req64), .mem_we(we64), .mem_be(be64), .mem_addr(maddr64),
        .mem_wdata(mwd64), .mem_ack(mem_ack & sel64), .mem_rdata(mem_rdata)
    );

    assign v_busy  = sel64 ? busy64  : busy32;
    assign v_done  = sel64 ? done64  : done32;
    assign v_req   = sel64 ? req64   : req32;
    assign v_we    = sel64 ? we64    : we32;
    assign v_rdata = sel64 ? rdata64 : {32'h0, rdata32};
    assign v_wdata = sel64 ? mwd64   : {32'h0, mwd32};
    assign v_addr  = sel64 ? maddr64 : maddr32;
    assign v_err   = sel64 ? err64   : err32;
    assign v_be    = sel64 ? be64    : {4'h0, be32};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge just after the accepting edge; acks after `waits`
    // request cycles (never if negative) and scores the done beat.
    task automatic run_ack(input int waits, input logic [63:0] mrd,
                           input logic [7:0] ebe, input logic [31:0] eaddr,
                           input logic [63:0] ewd, input logic ewe,
                           output int lat, output int reqs);
        logic [65:0] exp;
        lat  = 1;
        reqs = 0;
        while (!v_done && lat < 40) begin
            if (v_req) begin
                check("mem_be", v_be, ebe);
                check("mem_addr", v_addr, eaddr);
                check("mem_wdata", v_wdata, ewd);
                check("mem_we", v_we, ewe);
            end
            mem_ack   = v_req && (waits >= 0) && (reqs == waits);
            mem_rdata = mrd;
            if (v_req) reqs++;
            @(negedge clk);
            lat++;
        end
        mem_ack = 1'b0;
        check("done_seen", v_done, 1'b1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        if (v_done) check("result", {v_err, v_rdata}, exp);
    endtask

    task automatic access(input logic st, input logic [2:0] sz, input logic [31:0] a,
                          input logic [63:0] wd, input logic [63:0] mrd, input int waits,
                          input logic [1:0] exp_err, input logic [63:0] exp_rd,
                          input int exp_lat, input int exp_reqs,
                          input logic [7:0] ebe, input logic [31:0] eaddr,
                          input logic [63:0] ewd);
        int lat;
        int reqs;
        @(negedge clk);
        start = 1'b1; is_store = st; size = sz; addr = a; wdata = wd;
        exp_q.push_back({exp_err, exp_rd});
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", v_busy, 1'b1);
        run_ack(waits, mrd, ebe, eaddr, ewd, st, lat, reqs);
        check("latency", lat, exp_lat);
        check("req_cycles", reqs, exp_reqs);
        @(negedge clk);
        check("done_one_cycle", v_done, 1'b0);
        check("rdata_hold", v_rdata, exp_rd);
        check("idle_busy", v_busy, 1'b0);
    endtask

    initial begin
        int lat;
        int reqs;
        logic seen;
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; start = 1'b0; is_store = 1'b0; size = 3'b0; addr = '0;
        wdata = '0; mem_ack = 1'b0; mem_rdata = '0; sel64 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset32", {busy32, done32, rdata32, err32, req32, we32, be32, maddr32, mwd32}, '0);
        check("reset64", {busy64, done64, rdata64, err64, req64, we64, be64, maddr64, mwd64}, '0);
        rst = 1'b0;

        // 32-bit instance
        access(0, SZ_B,  32'h103, 64'h0, 64'h80FF_0000, 0, ERR_OK, 64'hFFFF_FF80, 2, 1, 8'b1000, 32'h100, 64'h0);
        access(1, SZ_H,  32'h202, 64'h1234_ABCD, 64'hFFFF_FFFF, 0, ERR_OK, 64'h0, 2, 1, 8'b1100, 32'h200, 64'hABCD_ABCD);
        access(0, SZ_W,  32'h6,   64'h0, 64'h0, 0, ERR_MISALIGN, 64'h0, 2, 0, 8'h0, 32'h0, 64'h0);
        access(0, SZ_D,  32'h0,   64'h0, 64'h0, 0, ERR_SIZE, 64'h0, 2, 0, 8'h0, 32'h0, 64'h0);
        access(0, SZ_D,  32'h1,   64'h0, 64'h0, 0, ERR_SIZE, 64'h0, 2, 0, 8'h0, 32'h0, 64'h0);
        access(1, SZ_BU, 32'h0,   64'h0, 64'h0, 0, ERR_SIZE, 64'h0, 2, 0, 8'h0, 32'h0, 64'h0);
        access(0, SZ_WU, 32'h0,   64'h0, 64'h0, 0, ERR_SIZE, 64'h0, 2, 0, 8'h0, 32'h0, 64'h0);
        access(0, SZ_HU, 32'h2,   64'h0, 64'h8001_1234, 2, ERR_OK, 64'h8001, 4, 3, 8'b1100, 32'h0, 64'h0);
        access(0, SZ_H,  32'h2,   64'h0, 64'h8001_1234, 0, ERR_OK, 64'hFFFF_8001, 2, 1, 8'b1100, 32'h0, 64'h0);
        access(1, SZ_B,  32'h1,   64'h55, 64'h0, 1, ERR_OK, 64'h0, 3, 2, 8'b0010, 32'h0, 64'h5555_5555);
        access(0, SZ_W,  32'h10,  64'h0, 64'h0, -1, ERR_TIMEOUT, 64'h0, 6, 4, 8'b1111, 32'h10, 64'h0);
        access(0, SZ_W,  32'h10,  64'h0, 64'hCAFE_F00D, 3, ERR_OK, 64'hCAFE_F00D, 5, 4, 8'b1111, 32'h10, 64'h0);

        // start held through an error done pulse is taken one cycle later
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; size = SZ_W; addr = 32'h6; wdata = '0;
        exp_q.push_back({ERR_MISALIGN, 64'h0});
        @(negedge clk);
        addr = 32'h20;
        @(negedge clk);
        check("err_done", v_done, 1'b1);
        check("err_result", {v_err, v_rdata}, exp_q.pop_front());
        exp_q.push_back({ERR_OK, 64'h1357_9BDF});
        @(negedge clk);
        check("start_ignored_on_done", v_req, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("accept_after_done", v_req, 1'b1);
        run_ack(0, 64'h1357_9BDF, 8'b1111, 32'h20, 64'h0, 1'b0, lat, reqs);
        @(negedge clk);

        // reset in the middle of a stalled access
        start = 1'b1; is_store = 1'b0; size = SZ_W; addr = 32'h40;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("req_before_reset", v_req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("req_after_reset", v_req, 1'b0);
        check("busy_after_reset", v_busy, 1'b0);
        check("rdata_after_reset", v_rdata, 64'h0);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 64'hFFFF_FFFF;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            seen = seen | v_done | v_req;
        end
        check("no_done_after_reset", seen, 1'b0);

        // 64-bit instance
        sel64 = 1'b1;
        access(0, SZ_WU, 32'h4,  64'h0, 64'hF000_0001_0000_0000, 0, ERR_OK, 64'h0000_0000_F000_0001, 2, 1, 8'hF0, 32'h0, 64'h0);
        access(0, SZ_W,  32'hC,  64'h0, 64'h8000_0000_1111_1111, 0, ERR_OK, 64'hFFFF_FFFF_8000_0000, 2, 1, 8'hF0, 32'h8, 64'h0);
        access(0, SZ_D,  32'h18, 64'h0, 64'h0123_4567_89AB_CDEF, 1, ERR_OK, 64'h0123_4567_89AB_CDEF, 3, 2, 8'hFF, 32'h18, 64'h0);
        access(1, SZ_D,  32'h4,  64'h0, 64'h0, 0, ERR_MISALIGN, 64'h0, 2, 0, 8'h0, 32'h0, 64'h0);
        access(1, SZ_W,  32'h4,  64'h1122_3344_5566_7788, 64'h0, 0, ERR_OK, 64'h0, 2, 1, 8'hF0, 32'h0, 64'h5566_7788_5566_7788);
        access(0, SZ_B,  32'h7,  64'h0, 64'h7F00_0000_0000_0000, 0, ERR_OK, 64'h7F, 2, 1, 8'h80, 32'h0, 64'h0);
        access(0, SZ_HU, 32'h3,  64'h0, 64'h0, 0, ERR_MISALIGN, 64'h0, 2, 0, 8'h0, 32'h0, 64'h0);

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
